pwr_seq_ctrl: RTL and testbench

Next-generation per-peripheral power sequencer; a multi-level successor to the 2-bit power FSM used in the power control subsystem.
- Goes beyond clock gating: adds retention and power-off levels, isolation control and a power-switch req/ack handshake with timeout.
- Sits between the idle predictor (sleep_eligible) / masked wake events and the clock gater plus power-switch cells.
- N independent channels, one 7-state FSM each.

---
 rtl/pwr_seq_ctrl.sv | 93 +++++++++
 tb/tb_pwr_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: per-channel ACTIVE/GATED/RET/OFF power sequencer with isolation and switch ack handshake.
// Define PWR_SEQ_STATS_EN to add per-channel OFF-entry counters (off_entries, stats_clr).
module pwr_seq_ctrl #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   periph_en,
  input  logic [N-1:0]   sleep_eligible,
  input  logic [N-1:0]   wake_evt,
  input  logic [W-1:0]   ret_th,
  input  logic [W-1:0]   off_th,
  input  logic [N-1:0]   pwr_ack,
  input  logic [N-1:0]   err_clr,
  output logic [N-1:0]   clk_req,
  output logic [N-1:0]   iso_en,
  output logic [N-1:0]   ret_save,
  output logic [N-1:0]   ret_restore,
  output logic [N-1:0]   pwr_sw_en,
  output logic [N*3-1:0] state,
`ifdef PWR_SEQ_STATS_EN
  input  logic           stats_clr,
  output logic [N*W-1:0] off_entries,
`endif
  output logic [N-1:0]   err_timeout
);
  typedef enum logic [2:0] {ACTIVE, GATED, RET, PD_WAIT, OFF, PU_WAIT, RESTORE} state_t;
  localparam logic [W-1:0] ONE = 1;
  localparam logic [W-1:0] TO_LAST = W'(ACK_TIMEOUT - 1);
  for (genvar c = 0; c < N; c++) begin : g_ch
    state_t st, st_n;
    logic [W-1:0] dwell;
    logic pend, pend_n, err, err_set, wake;
    assign wake = wake_evt[c] | ~periph_en[c];
    always_comb begin
      st_n = st;
      err_set = 1'b0;
      case (st)
        ACTIVE:  st_n = (sleep_eligible[c] && !wake) ? GATED : ACTIVE;
        GATED:   st_n = (wake || !sleep_eligible[c]) ? ACTIVE :
                        (ret_th != '0 && dwell == ret_th - ONE) ? RET : GATED;
        RET:     st_n = wake ? RESTORE : (off_th != '0 && dwell == off_th - ONE) ? PD_WAIT : RET;
        PD_WAIT: begin
          err_set = pwr_ack[c] && dwell == TO_LAST;
          st_n = !pwr_ack[c] ? OFF : err_set ? PU_WAIT : PD_WAIT;
        end
        OFF:     st_n = (wake || pend) ? PU_WAIT : OFF;
        PU_WAIT: begin
          err_set = !pwr_ack[c] && dwell == TO_LAST;
          st_n = pwr_ack[c] ? RESTORE : PU_WAIT;
        end
        RESTORE: st_n = ACTIVE;
        default: st_n = ACTIVE;
      endcase
    end
    // A wake during power-down is remembered until the channel has left OFF.
    assign pend_n = (st == PD_WAIT) ? (pend | wake) : (st == OFF && st_n == OFF) ? pend : 1'b0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st    <= ACTIVE;
        dwell <= '0;
        pend  <= 1'b0;
        err   <= 1'b0;
      end else begin
        st    <= st_n;
        dwell <= (st_n != st) ? '0 : (&dwell) ? dwell : dwell + ONE;
        pend  <= pend_n;
        err   <= err_set | (err & ~err_clr[c]);
      end
    end
    assign clk_req[c]      = st == ACTIVE || st == RESTORE;
    assign iso_en[c]       = st != ACTIVE && st != GATED;
    assign pwr_sw_en[c]    = st != PD_WAIT && st != OFF;
    assign ret_save[c]     = st == RET && dwell == '0;
    assign ret_restore[c]  = st == RESTORE;
    assign state[c*3 +: 3] = st;
    assign err_timeout[c]  = err;
`ifdef PWR_SEQ_STATS_EN
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt <= '0;
      else if (stats_clr)
        cnt <= '0;
      else if (st == PD_WAIT && st_n == OFF && !(&cnt))
        cnt <= cnt + ONE;
    end
    assign off_entries[c*W +: W] = cnt;
`endif
  end
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: directed scenarios for pwr_seq_ctrl with hand-computed expectations.
module tb_pwr_seq_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] periph_en = '1, sleep_eligible = '0, wake_evt = '0, pwr_ack = '1, err_clr = '0;
  logic [W-1:0] ret_th = '0, off_th = '0;
  logic [N-1:0] clk_req, iso_en, ret_save, ret_restore, pwr_sw_en, err_timeout;
  logic [N*3-1:0] state;
  int n_chk = 0;
  int n_fail = 0;
`ifdef PWR_SEQ_STATS_EN
  logic stats_clr = 1'b0;
  logic [N*W-1:0] off_entries;
`endif

  pwr_seq_ctrl #(.N(N), .W(W), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .periph_en(periph_en), .sleep_eligible(sleep_eligible),
    .wake_evt(wake_evt), .ret_th(ret_th), .off_th(off_th), .pwr_ack(pwr_ack),
    .err_clr(err_clr), .clk_req(clk_req), .iso_en(iso_en), .ret_save(ret_save),
    .ret_restore(ret_restore), .pwr_sw_en(pwr_sw_en), .state(state),
`ifdef PWR_SEQ_STATS_EN
    .stats_clr(stats_clr), .off_entries(off_entries),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] st(int c);
    return state[c*3 +: 3];
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({state, clk_req, iso_en, pwr_sw_en, ret_save, ret_restore, err_timeout} !== {12'h000, 4'hf, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset: state=%h clk_req=%h iso=%h sw=%h err=%h, required 000 f 0 f 0", state, clk_req, iso_en, pwr_sw_en, err_timeout);
    end
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gated();
    ret_th = 0;
    sleep_eligible[0] = 1'b1;
    tick();
    n_chk++;
    if (st(0) !== 3'd1 || clk_req[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_entry: state=%0d clk_req=%b, required 1 0", st(0), clk_req[0]);
    end
    tick(9);
    n_chk++;
    if (st(0) !== 3'd1 || iso_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_hold: state=%0d iso=%b, required 1 0", st(0), iso_en[0]);
    end
    sleep_eligible[0] = 1'b0;
    tick();
    n_chk++;
    if (st(0) !== 3'd0 || clk_req[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL gated_exit: state=%0d clk_req=%b, required 0 1", st(0), clk_req[0]);
    end
  endtask

  task automatic test_retention();
    ret_th = 5;
    off_th = 0;
    sleep_eligible[0] = 1'b1;
    tick(5);
    n_chk++;
    if (st(0) !== 3'd1) begin
      n_fail++;
      $display("FAIL ret_gated5: state=%0d, required 1", st(0));
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd2 || ret_save[0] !== 1'b1 || iso_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_entry: state=%0d save=%b iso=%b, required 2 1 1", st(0), ret_save[0], iso_en[0]);
    end
    tick();
    n_chk++;
    if (ret_save[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_save_pulse: save=%b, required 0", ret_save[0]);
    end
    tick(8);
    n_chk++;
    if (st(0) !== 3'd2 || pwr_sw_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_hold: state=%0d sw=%b, required 2 1", st(0), pwr_sw_en[0]);
    end
    wake_evt[0] = 1'b1;
    tick();
    wake_evt[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd6 || ret_restore[0] !== 1'b1 || clk_req[0] !== 1'b1 || iso_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_restore: state=%0d restore=%b clk_req=%b iso=%b, required 6 1 1 1", st(0), ret_restore[0], clk_req[0], iso_en[0]);
    end
    tick();
    sleep_eligible[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd0 || iso_en[0] !== 1'b0 || ret_restore[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_active: state=%0d iso=%b restore=%b, required 0 0 0", st(0), iso_en[0], ret_restore[0]);
    end
    tick();
  endtask

  task automatic test_power_cycle();
    ret_th = 2;
    off_th = 3;
    sleep_eligible[0] = 1'b1;
    tick(5);
    n_chk++;
    if (st(0) !== 3'd2) begin
      n_fail++;
      $display("FAIL pd_ret: state=%0d, required 2", st(0));
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd3 || pwr_sw_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pd_wait: state=%0d sw=%b, required 3 0", st(0), pwr_sw_en[0]);
    end
    tick(3);
    pwr_ack[0] = 1'b0;
    tick();
    n_chk++;
    if (st(0) !== 3'd4 || pwr_sw_en[0] !== 1'b0 || iso_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pd_off: state=%0d sw=%b iso=%b, required 4 0 1", st(0), pwr_sw_en[0], iso_en[0]);
    end
    tick(3);
    wake_evt[0] = 1'b1;
    tick();
    wake_evt[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd5 || pwr_sw_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pu_wait: state=%0d sw=%b, required 5 1", st(0), pwr_sw_en[0]);
    end
    tick(5);
    pwr_ack[0] = 1'b1;
    tick();
    sleep_eligible[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd6 || ret_restore[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pu_restore: state=%0d restore=%b, required 6 1", st(0), ret_restore[0]);
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd0 || err_timeout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pu_active: state=%0d err=%b, required 0 0", st(0), err_timeout[0]);
    end
  endtask

  task automatic test_ack_timeout();
    ret_th = 1;
    off_th = 1;
    sleep_eligible[0] = 1'b1;
    tick(3);
    err_clr[0] = 1'b1;
    tick(63);
    n_chk++;
    if (st(0) !== 3'd3 || err_timeout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_wait63: state=%0d err=%b, required 3 0", st(0), err_timeout[0]);
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd5 || err_timeout[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL to_abort: state=%0d err=%b, required 5 1", st(0), err_timeout[0]);
    end
    tick();
    sleep_eligible[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd6 || err_timeout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: state=%0d err=%b, required 6 0", st(0), err_timeout[0]);
    end
    err_clr[0] = 1'b0;
    tick();
  endtask

  task automatic test_pending_priority();
    ret_th = 1;
    off_th = 1;
    sleep_eligible[0] = 1'b1;
    tick(3);
    wake_evt[0] = 1'b1;
    tick();
    wake_evt[0] = 1'b0;
    pwr_ack[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd3) begin
      n_fail++;
      $display("FAIL pend_wait: state=%0d, required 3", st(0));
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd4) begin
      n_fail++;
      $display("FAIL pend_off: state=%0d, required 4", st(0));
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd5) begin
      n_fail++;
      $display("FAIL pend_pu: state=%0d, required 5", st(0));
    end
    tick(63);
    n_chk++;
    if (err_timeout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pu_to63: err=%b, required 0", err_timeout[0]);
    end
    tick();
    n_chk++;
    if (st(0) !== 3'd5 || err_timeout[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pu_to: state=%0d err=%b, required 5 1", st(0), err_timeout[0]);
    end
    pwr_ack[0] = 1'b1;
    sleep_eligible[0] = 1'b0;
    tick(2);
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd0 || err_timeout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pu_recover: state=%0d err=%b, required 0 0", st(0), err_timeout[0]);
    end
    ret_th = 3;
    off_th = 0;
    sleep_eligible[0] = 1'b1;
    tick(3);
    wake_evt[0] = 1'b1;
    tick();
    wake_evt[0] = 1'b0;
    sleep_eligible[0] = 1'b0;
    n_chk++;
    if (st(0) !== 3'd0 || ret_save[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_prio: state=%0d save=%b, required 0 0", st(0), ret_save[0]);
    end
    tick();
  endtask

  task automatic test_reset_independence();
    ret_th = 1;
    off_th = 1;
    periph_en[2] = 1'b0;
    sleep_eligible = 4'b0111;
    tick(3);
    pwr_ack[1:0] = 2'b00;
    tick();
    wake_evt[1] = 1'b1;
    tick();
    wake_evt[1] = 1'b0;
    n_chk++;
    if (state !== {3'd0, 3'd0, 3'd5, 3'd4}) begin
      n_fail++;
      $display("FAIL indep: state=%h, required %h", state, {3'd0, 3'd0, 3'd5, 3'd4});
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (state !== '0 || pwr_sw_en !== 4'hf || clk_req !== 4'hf || iso_en !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: state=%h sw=%h clk_req=%h iso=%h, required 000 f f 0", state, pwr_sw_en, clk_req, iso_en);
    end
    sleep_eligible = '0;
    pwr_ack = '1;
    periph_en = '1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gated();
    test_retention();
    test_power_cycle();
    test_ack_timeout();
    test_pending_priority();
    test_reset_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
